// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider.
// Holds the state encodings, the default widths and the divide-by-zero result fill.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // A zero divisor yields an all-ones quotient; this is the replicated bit.
    localparam logic DIV_DBZ_FILL = 1'b1;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
// Purely combinational so a wider-radix variant can chain two of these per cycle.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        // When the trial fits the difference is below the divisor, so the top bit drops cleanly.
        rem_o   = fits ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the EX stage; stalls the pipe while iterating.
// Operands are taken as magnitudes, divided unsigned, and sign-fixed in the done cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for start; no stall unless an op is being accepted
// DIV_BUSY | one quotient bit per cycle, WIDTH cycles, stall held
// DIV_DONE | result valid for one cycle, stall released
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             pause_ex,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hold_quo_q, hold_quo_d;
    logic [WIDTH-1:0] hold_rem_q, hold_rem_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] fix_quo, fix_rem;
    logic             is_done;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        a_neg   = signed_op & dividend[WIDTH-1];
        b_neg   = signed_op & divisor[WIDTH-1];
        a_abs   = a_neg ? -dividend : dividend;
        b_abs   = b_neg ? -divisor  : divisor;
        fix_quo = neg_quo_q ? -quo_q : quo_q;
        fix_rem = neg_rem_q ? -rem_q : rem_q;
        is_done = (state_q == DIV_DONE) & ~cancel;

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hold_quo_d = hold_quo_q;
        hold_rem_d = hold_rem_q;
        pause_ex   = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    pause_ex = 1'b1;
                    cnt_d    = '0;
                    if (divisor == '0) begin
                        // Divide-by-zero skips iteration and sign fixup entirely.
                        state_d   = DIV_DONE;
                        quo_d     = {WIDTH{DIV_DBZ_FILL}};
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = DIV_BUSY;
                        quo_d     = a_abs;
                        rem_d     = '0;
                        dvs_d     = b_abs;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            DIV_BUSY: begin
                pause_ex = ~cancel;
                rem_d    = step_rem;
                quo_d    = step_quo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
                if (!cancel) begin
                    hold_quo_d = fix_quo;
                    hold_rem_d = fix_rem;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (cancel) begin
            state_d = DIV_IDLE;
        end

        done      = is_done;
        quotient  = is_done ? fix_quo : hold_quo_q;
        remainder = is_done ? fix_rem : hold_rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hold_quo_q <= '0;
            hold_rem_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hold_quo_q <= hold_quo_d;
            hold_rem_q <= hold_rem_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-stepped driver, arithmetic reference model, per-cycle compare.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         pause_ex, done;
    logic [W-1:0] quotient, remainder;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .pause_ex  (pause_ex),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         chk_en = 1'b0;
    logic         exp_pause = 1'b0, exp_done = 1'b0;
    logic [W-1:0] exp_q = '0, exp_r = '0;
    logic [W-1:0] held_q = '0, held_r = '0;
    int           n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, expv);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pause_ex", W'(pause_ex), W'(exp_pause));
            chk("done", W'(done), W'(exp_done));
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
        end
    end

    function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, qq, rr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic step(input logic r, input logic s, input logic c,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input logic ep, input logic ed,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
        @(posedge clk);
        #1;
        rst = r; start = s; cancel = c;
        dividend = a; divisor = b; signed_op = sg;
        exp_pause = ep; exp_done = ed; exp_q = eq; exp_r = er;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, held_q, held_r);
    endtask

    // Start held from cycle 0 through the done cycle; cancel_at < 0 means no cancel.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input int cancel_at, output int dcyc,
                          output logic [W-1:0] gq, output logic [W-1:0] gr);
        logic [W-1:0] eq, er;
        int lat;
        ref_div(sg, a, b, eq, er);
        lat  = (b == '0) ? 1 : W + 1;
        dcyc = -1; gq = '0; gr = '0;
        for (int k = 0; k <= lat; k++) begin
            logic c;
            c = (k == cancel_at);
            if (k < lat) step(0, 1, c, a, b, sg, !c, 0, held_q, held_r);
            else         step(0, 1, c, a, b, sg, 0, !c, c ? held_q : eq, c ? held_r : er);
            if (c) begin
                step(0, 0, 0, a, b, sg, 0, 0, held_q, held_r);
                return;
            end
            if (k == lat) begin
                dcyc = cyc;
                @(negedge clk);
                #1;
                gq = quotient;
                gr = remainder;
                held_q = eq;
                held_r = er;
            end
        end
    endtask

    initial begin
        int d1, d2, d0;
        logic [W-1:0] gq, gr, mq, mr, a, b;
        logic sg;
        int lat, cat;

        // model pins
        ref_div(0, 100, 7, mq, mr);                         chk("model 100/7 q", mq, 14);
        ref_div(1, 32'hFFFFFFF9, 2, mq, mr);                chk("model -7/2 r", mr, 32'hFFFFFFFF);
        ref_div(1, 32'h80000000, 32'hFFFFFFFF, mq, mr);     chk("model ovf q", mq, 32'h80000000);

        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk); #1;
        chk("reset quotient", quotient, '0);
        idle(1);

        run_op(100, 7, 0, -1, d1, gq, gr);
        chk("100/7 q", gq, 14);                chk("100/7 r", gr, 2);
        idle(1);
        run_op(32'hFFFFFFF9, 2, 1, -1, d1, gq, gr);
        chk("-7/2 q", gq, 32'hFFFFFFFD);       chk("-7/2 r", gr, 32'hFFFFFFFF);
        run_op(7, 32'hFFFFFFFE, 1, -1, d1, gq, gr);
        chk("7/-2 q", gq, 32'hFFFFFFFD);       chk("7/-2 r", gr, 1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1, -1, d1, gq, gr);
        chk("ovf q", gq, 32'h80000000);        chk("ovf r", gr, 0);
        run_op(32'hFFFFFFFF, 1, 0, -1, d1, gq, gr);
        chk("max/1 q", gq, 32'hFFFFFFFF);      chk("max/1 r", gr, 0);
        idle(2);

        d0 = cyc + 1;
        run_op(32'h1234, 0, 1, -1, d1, gq, gr);
        chk("dbz q", gq, 32'hFFFFFFFF);        chk("dbz r", gr, 32'h1234);
        chk("dbz latency", W'(d1 - d0), 1);
        idle(1);

        run_op(50, 5, 0, 10, d1, gq, gr);
        run_op(9, 3, 0, -1, d1, gq, gr);
        chk("9/3 after cancel q", gq, 3);      chk("9/3 after cancel r", gr, 0);
        idle(1);

        run_op(20, 6, 0, -1, d1, gq, gr);
        run_op(15, 4, 0, -1, d2, gq, gr);
        chk("b2b q", gq, 3);                   chk("b2b r", gr, 3);
        chk("b2b spacing", W'(d2 - d1), 34);
        idle(1);

        for (int k = 0; k < 7; k++) step(0, 1, 0, 50, 5, 0, 1, 0, held_q, held_r);
        step(1, 1, 0, 50, 5, 0, 1, 0, held_q, held_r);
        held_q = '0; held_r = '0;
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk); #1;
        chk("rst mid-busy pause", W'(pause_ex), 0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF;
                3: b = $urandom;
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = 1;
            endcase
            lat = (b == '0) ? 1 : W + 1;
            cat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat) : -1;
            run_op(a, b, sg, cat, d1, gq, gr);
            idle($urandom_range(0, 2));
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
